xlib_avalon_bus_w_rr: RTL

XLIB_AVALON_BUS_W_RR -- requirements
Module: xlib_avalon_bus_w_rr

---
 rtl/xlib_avalon_bus_w_rr.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/xlib_avalon_bus_w_rr.sv
// Arbitrated N-to-1 Avalon-style write burst bus; a grant is held for a whole burst.
// Define XLIB_AVALON_BUS_W_RR_RR_EN for round-robin arbitration (default: fixed priority, highest index wins).
module xlib_avalon_bus_w_rr #(
    parameter int NR = 4,
    parameter int DW = 32,
    parameter int AW = 32,
    parameter int BL = 4,
    parameter int BI = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NR-1:0]         s_wval,
    input  logic [NR*BL-1:0]      s_wlen,
    input  logic [NR*AW-1:0]      s_waddr,
    input  logic [NR*DW-1:0]      s_wdata,
    input  logic [NR*(DW/8)-1:0]  s_wbe,
    output logic [NR-1:0]         s_wrdy,
    input  logic                  m_wrdy,
    output logic                  m_wval,
    output logic [BL-1:0]         m_wlen,
    output logic [AW-1:0]         m_waddr,
    output logic [DW-1:0]         m_wdata,
    output logic [DW/8-1:0]       m_wbe,
    output logic                  busy,
    output logic [$clog2(NR)-1:0] gid
);

    localparam int GW = $clog2(NR);
    localparam int BW = DW / 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic [GW-1:0] gid_r;
    logic [GW-1:0] win_s;
    logic [BL-1:0] cnt_r;
    logic [BL-1:0] len_q_r;
    logic [BL-1:0] len_g_s;
    logic [BL-1:0] len_eff_s;
    logic          xfer_s;
    logic          first_s;
    logic          last_s;

    // Slice the granted requester onto the master port and derive beat bookkeeping.
    always_comb begin
        len_g_s   = s_wlen[int'(gid_r)*BL +: BL];
        m_wlen    = len_g_s;
        m_waddr   = s_waddr[int'(gid_r)*AW +: AW];
        m_wdata   = s_wdata[int'(gid_r)*DW +: DW];
        m_wbe     = s_wbe[int'(gid_r)*BW +: BW];
        m_wval    = (state_r == BURST) && s_wval[gid_r];
        xfer_s    = m_wval && m_wrdy;
        first_s   = (cnt_r == BL'(BI));
        // len_q is not yet valid on the first beat, so the live length decides there.
        len_eff_s = first_s ? len_g_s : len_q_r;
        last_s    = (cnt_r >= len_eff_s);
        busy      = (state_r == BURST);
        gid       = gid_r;
    end

    // Beat accept is steered to the granted requester only while a burst is open.
    always_comb begin
        s_wrdy = {NR{1'b0}};
        if ((state_r == BURST) && m_wrdy) begin
            s_wrdy[gid_r] = 1'b1;
        end else begin
            s_wrdy = {NR{1'b0}};
        end
    end

`ifdef XLIB_AVALON_BUS_W_RR_RR_EN
    logic [GW-1:0] ptr_r;

    // Round-robin winner: scan from ptr+1 upward, the pointer itself last.
    always_comb begin
        win_s = {GW{1'b0}};
        for (int k = NR; k >= 1; k--) begin
            if (s_wval[(int'(ptr_r) + k) % NR]) begin
                win_s = GW'((int'(ptr_r) + k) % NR);
            end else begin
                win_s = win_s;
            end
        end
    end

    // Round-robin pointer follows the most recent grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= GW'(NR - 1);
        end else if ((state_r == IDLE) && (|s_wval)) begin
            ptr_r <= win_s;
        end
    end
`else
    // Fixed priority winner: highest requesting index.
    always_comb begin
        win_s = {GW{1'b0}};
        for (int i = 0; i < NR; i++) begin
            if (s_wval[i]) begin
                win_s = GW'(i);
            end else begin
                win_s = win_s;
            end
        end
    end
`endif

    // FSM next state: one arbitration cycle, then stay until the last beat moves.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (|s_wval) begin
                    state_s = BURST;
                end else begin
                    state_s = IDLE;
                end
            end
            BURST: begin
                if (xfer_s && last_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = BURST;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State, grant, beat counter and captured burst length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            gid_r   <= {GW{1'b0}};
            cnt_r   <= BL'(BI);
            len_q_r <= {BL{1'b0}};
        end else begin
            state_r <= state_s;
            if ((state_r == IDLE) && (|s_wval)) begin
                gid_r <= win_s;
            end
            if (xfer_s) begin
                if (first_s) begin
                    len_q_r <= len_g_s;
                end
                if (last_s) begin
                    cnt_r <= BL'(BI);
                end else begin
                    cnt_r <= cnt_r + BL'(1);
                end
            end
        end
    end

endmodule
